// File: rtl/regfile_read_pkg.sv
// Shared types and constants for the register file read side.
//   XLEN / NREG / AW : data width, register count, register index width
//   rf_state_t       : read-handshake FSM states
//   operands_t       : latched operand pair presented to decode/execute
package regfile_read_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xdata_t;

  localparam reg_addr_t REG_ZERO = AW'(0);

  typedef enum logic [1:0] {
    RF_IDLE = 2'd0,
    RF_WAIT = 2'd1,
    RF_DONE = 2'd2
  } rf_state_t;

  typedef struct packed {
    xdata_t rs1;
    xdata_t rs2;
  } operands_t;

  // True when the write-back port is delivering register a this cycle.
  function automatic logic wb_hits(input logic en, input reg_addr_t wa, input reg_addr_t a);
    return en && (wa == a);
  endfunction

endpackage

// File: rtl/regfile_read_if.sv
// Operand-read handshake between decode/execute (master) and the register file (slave).
//   enabled            request strobe, sampled while the register file is idle
//   rs1_addr/rs2_addr  source indices captured with the request
//   rs1_data/rs2_data  operands, valid with completed and held until the next read
//   completed          one-cycle pulse: operands valid
//   stalled            high while a source is waiting on an outstanding write-back
interface regfile_read_if;
  import regfile_read_pkg::*;

  logic      enabled;
  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  xdata_t    rs1_data;
  xdata_t    rs2_data;
  logic      completed;
  logic      stalled;

  modport master (
    output enabled, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, completed, stalled
  );

  modport slave (
    input  enabled, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, completed, stalled
  );

endinterface

// File: rtl/regfile_read_scoreboard.sv
// Per-register pending bits for outstanding write-backs.
//   clk, rstn                 clock, async active-low reset (clears all pending bits)
//   rsv_enabled/rsv_addr      mark a register as having a producer in flight
//   clr_enabled/clr_addr      write-back retiring a producer
//   q1_addr/q2_addr           hazard query indices
//   q1_hazard_c/q2_hazard_c   combinational: source must wait
module regfile_read_scoreboard
  import regfile_read_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      rsv_enabled,
  input  reg_addr_t rsv_addr,
  input  logic      clr_enabled,
  input  reg_addr_t clr_addr,
  input  reg_addr_t q1_addr,
  input  reg_addr_t q2_addr,
  output logic      q1_hazard_c,
  output logic      q2_hazard_c
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;

  // Clear first so a same-cycle reserve (new producer) wins; x0 is never pending.
  always_comb begin
    pending_next = pending;
    if (clr_enabled) pending_next[clr_addr] = 1'b0;
    if (rsv_enabled) pending_next[rsv_addr] = 1'b1;
    pending_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pending <= '0;
    else       pending <= pending_next;
  end

  // A write-back landing this cycle satisfies the query via the bypass path.
  always_comb begin
    q1_hazard_c = pending[q1_addr] && !wb_hits(clr_enabled, clr_addr, q1_addr)
                  && (q1_addr != REG_ZERO);
    q2_hazard_c = pending[q2_addr] && !wb_hits(clr_enabled, clr_addr, q2_addr)
                  && (q2_addr != REG_ZERO);
  end

endmodule

// File: rtl/regfile_read.sv
// Integer register file with a stalling two-operand read handshake.
//   clk, rstn                        clock, async active-low reset
//   bus (slave)                      read request / operand return handshake
//   rsv_enabled/rsv_addr             reserve destination of an issued instruction
//   reg_w_enabled/addr/data          write-back port (bypassed to same-cycle reads)
module regfile_read
  import regfile_read_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  regfile_read_if.slave  bus,
  input  logic           rsv_enabled,
  input  reg_addr_t      rsv_addr,
  input  logic           reg_w_enabled,
  input  reg_addr_t      reg_w_addr,
  input  xdata_t         reg_w_data
);

  rf_state_t state;
  rf_state_t state_next;

  xdata_t    regs [NREG];
  reg_addr_t lat1_addr;
  reg_addr_t lat2_addr;
  reg_addr_t sel1_addr;
  reg_addr_t sel2_addr;
  logic      hazard1;
  logic      hazard2;
  logic      accept;
  logic      op_load;
  logic      completed_d;
  logic      stalled_d;
  operands_t ops;
  operands_t ops_mux;
  logic      completed_q;
  logic      stalled_q;

  // Register array; x0 is never written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (reg_w_enabled && (reg_w_addr != REG_ZERO)) begin
      regs[reg_w_addr] <= reg_w_data;
    end
  end

  // Idle evaluates the incoming request; waiting re-evaluates the captured one.
  always_comb begin
    sel1_addr = (state == RF_IDLE) ? bus.rs1_addr : lat1_addr;
    sel2_addr = (state == RF_IDLE) ? bus.rs2_addr : lat2_addr;
  end

  regfile_read_scoreboard u_sb (
    .clk         (clk),
    .rstn        (rstn),
    .rsv_enabled (rsv_enabled),
    .rsv_addr    (rsv_addr),
    .clr_enabled (reg_w_enabled),
    .clr_addr    (reg_w_addr),
    .q1_addr     (sel1_addr),
    .q2_addr     (sel2_addr),
    .q1_hazard_c (hazard1),
    .q2_hazard_c (hazard2)
  );

  // Operand source: x0 -> 0, same-cycle write-back -> bypass, else array.
  always_comb begin
    ops_mux = '0;
    if (sel1_addr == REG_ZERO)                              ops_mux.rs1 = '0;
    else if (wb_hits(reg_w_enabled, reg_w_addr, sel1_addr)) ops_mux.rs1 = reg_w_data;
    else                                                    ops_mux.rs1 = regs[sel1_addr];
    if (sel2_addr == REG_ZERO)                              ops_mux.rs2 = '0;
    else if (wb_hits(reg_w_enabled, reg_w_addr, sel2_addr)) ops_mux.rs2 = reg_w_data;
    else                                                    ops_mux.rs2 = regs[sel2_addr];
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RF_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      RF_IDLE: if (bus.enabled) state_next = (hazard1 || hazard2) ? RF_WAIT : RF_DONE;
      RF_WAIT: if (!(hazard1 || hazard2)) state_next = RF_DONE;
      RF_DONE: state_next = RF_IDLE;
      default: state_next = RF_IDLE;
    endcase
  end

  // Output/control decode; completed and stalled are registered from the next state.
  always_comb begin
    accept      = 1'b0;
    op_load     = 1'b0;
    completed_d = 1'b0;
    stalled_d   = 1'b0;
    accept      = (state == RF_IDLE) && bus.enabled;
    op_load     = (accept || (state == RF_WAIT)) && !(hazard1 || hazard2);
    completed_d = (state_next == RF_DONE);
    stalled_d   = (state_next == RF_WAIT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat1_addr   <= REG_ZERO;
      lat2_addr   <= REG_ZERO;
      ops         <= '0;
      completed_q <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      if (accept) begin
        lat1_addr <= bus.rs1_addr;
        lat2_addr <= bus.rs2_addr;
      end
      if (op_load) ops <= ops_mux;
      completed_q <= completed_d;
      stalled_q   <= stalled_d;
    end
  end

  assign bus.rs1_data  = ops.rs1;
  assign bus.rs2_data  = ops.rs2;
  assign bus.completed = completed_q;
  assign bus.stalled   = stalled_q;

endmodule
